// File: rtl/alu_mul_sequencer.sv
// Unsigned 32x32->64 shift-and-add multiplier driving the shared ALU in ADD mode; each add is held SETTLE_CYCLES.
// Latency 32 + popcount(multiplier)*SETTLE_CYCLES cycles; in_ready only in IDLE; product held until out_ready.
module alu_mul_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_mcand,
  input  logic [31:0] in_mplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        out_hi_nonzero,
  output logic        busy,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic        alu_command,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_ADD,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mcand;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [4:0]    r_bitcnt;
  logic [SW-1:0] r_settle;
  logic [31:0]   w_mcand_nxt;
  logic [31:0]   w_hi_nxt;
  logic [31:0]   w_lo_nxt;
  logic [4:0]    w_bitcnt_nxt;
  logic [SW-1:0] w_settle_nxt;
  logic          w_last_bit;

  assign w_last_bit = (r_bitcnt == 5'd31);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_bitcnt <= '0;
      r_settle <= '0;
    end else begin
      r_mcand  <= w_mcand_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_bitcnt_nxt = r_bitcnt;
    w_settle_nxt = r_settle;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_mcand_nxt  = in_mcand;
          w_lo_nxt     = in_mplier;
          w_hi_nxt     = '0;
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (r_lo[0]) begin
          w_settle_nxt = '0;
          w_state_nxt  = S_ADD;
        end else begin
          w_hi_nxt     = {1'b0, r_hi[31:1]};
          w_lo_nxt     = {r_hi[0], r_lo[31:1]};
          w_bitcnt_nxt = r_bitcnt + 5'd1;
          if (w_last_bit) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ADD: begin
        // ALU inputs (hi, mcand) stay frozen here; the 33-bit sum is only trusted on the last settle cycle.
        w_settle_nxt = r_settle + SW'(1);
        if (r_settle == SETTLE_LAST) begin
          w_hi_nxt     = {alu_carryout, alu_result[31:1]};
          w_lo_nxt     = {alu_result[0], r_lo[31:1]};
          w_bitcnt_nxt = r_bitcnt + 5'd1;
          w_state_nxt  = w_last_bit ? S_DONE : S_EVAL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready       = (r_state == S_IDLE);
  assign out_valid      = (r_state == S_DONE);
  assign out_product    = out_valid ? {r_hi, r_lo} : 64'd0;
  assign out_hi_nonzero = out_valid && (r_hi != 32'd0);
  assign busy           = (r_state == S_EVAL) || (r_state == S_ADD);
  assign alu_operand_a  = r_hi;
  assign alu_operand_b  = r_mcand;
  assign alu_command    = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: slow-settling ALU model, transaction-level reference, directed vectors.
module tb_alu_mul_sequencer;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mcand;
  logic [31:0] in_mplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        out_hi_nonzero;
  logic        busy;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic        alu_command;
  logic [31:0] alu_result = '0;
  logic        alu_carryout = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mplier(in_mplier),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_hi_nonzero(out_hi_nonzero),
    .busy(busy),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_command(alu_command),
    .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ALU returns a wrong sum until its operands have been stable for S sampling points.
  logic        alu_bad = 1'b0;
  logic [31:0] p_a, p_b;
  logic [32:0] alu_sum;
  int          stable = 0;
  always @(negedge clk) begin
    if (alu_operand_a === p_a && alu_operand_b === p_b) stable++;
    else stable = 0;
    p_a = alu_operand_a;
    p_b = alu_operand_b;
    alu_sum = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
    if (stable >= S && !alu_bad) {alu_carryout, alu_result} = alu_sum;
    else {alu_carryout, alu_result} = ~alu_sum;
  end

  // Transaction-level reference: product by arithmetic, completion by popcount latency.
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t        m_ph = M_IDLE;
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_en = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = M_IDLE; m_prod = '0; m_a = '0; m_b = '0; m_en = 1'b1;
    end else begin
      case (m_ph)
        M_IDLE: if (in_valid) begin
          m_prod = 64'(in_mcand) * 64'(in_mplier);
          m_left = 32 + $countones(in_mplier) * S;
          m_b    = in_mcand;
          m_ph   = M_RUN;
        end
        M_RUN: begin
          m_left--;
          if (m_left == 0) begin
            m_ph = M_DONE;
            m_a  = m_prod[63:32];
          end
        end
        M_DONE: if (out_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("in_ready", in_ready, m_ph == M_IDLE);
      chk("out_valid", out_valid, m_ph == M_DONE);
      chk("out_product", out_product, (m_ph == M_DONE) ? m_prod : 64'd0);
      chk("out_hi_nonzero", out_hi_nonzero, (m_ph == M_DONE) && (m_prod[63:32] != 0));
      chk("busy", busy, m_ph == M_RUN);
      chk("alu_command", alu_command, 1'b0);
      chk("alu_operand_b", alu_operand_b, m_b);
      if (m_ph != M_RUN) chk("alu_operand_a", alu_operand_a, m_a);
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 500) begin wait_cycle(); t++; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 2000) begin wait_cycle(); n++; end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] ep, input int el, input string nm);
    int n;
    wait_ready();
    in_valid = 1'b1; in_mcand = a; in_mplier = b;
    wait_cycle();
    in_valid = 1'b0; in_mcand = $urandom; in_mplier = $urandom;
    wait_valid(n);
    chk({nm, " latency"}, 64'(n), 64'(el));
    chk({nm, " product"}, out_product, ep);
    chk({nm, " hi_nonzero"}, out_hi_nonzero, ep[63:32] != 0);
    out_ready = 1'b1;
    wait_cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mcand = '0; in_mplier = '0;
    repeat (2) wait_cycle();
    rst_n = 1'b1;
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_product", out_product, 64'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst alu_a", alu_operand_a, 32'd0);
    chk("rst alu_b", alu_operand_b, 32'd0);

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 40, "basic");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 160, "carry");
    alu_bad = 1'b1;
    run_op(32'h1234_5678, 32'd0, 64'd0, 32, "zero");
    alu_bad = 1'b0;

    // Backpressure with a second operand pair offered the whole time.
    wait_ready();
    in_valid = 1'b1; in_mcand = 32'h0001_0000; in_mplier = 32'h0001_0000;
    wait_cycle();
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp first latency", 64'(n), 64'd36);
    in_valid = 1'b1; in_mcand = 32'd7; in_mplier = 32'd9;
    for (int i = 0; i < 10; i++) begin
      wait_cycle();
      chk("bp held product", out_product, 64'h0000_0001_0000_0000);
      chk("bp held in_ready", in_ready, 1'b0);
      chk("bp held hi_nonzero", out_hi_nonzero, 1'b1);
    end
    out_ready = 1'b1;
    wait_cycle();
    out_ready = 1'b0;
    chk("bp idle in_ready", in_ready, 1'b1);
    chk("bp idle out_valid", out_valid, 1'b0);
    wait_cycle();
    in_valid = 1'b0; in_mcand = $urandom; in_mplier = $urandom;
    chk("bp second accepted", busy, 1'b1);
    wait_valid(n);
    chk("bp second latency", 64'(n), 64'd40);
    chk("bp second product", out_product, 64'd63);
    out_ready = 1'b1;
    wait_cycle();
    out_ready = 1'b0;

    // Reset with random inputs while an operation is in flight.
    wait_ready();
    in_valid = 1'b1; in_mcand = $urandom; in_mplier = $urandom;
    wait_cycle();
    repeat (5) wait_cycle();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_mcand = $urandom; in_mplier = $urandom;
      wait_cycle();
      chk("rnd rst in_ready", in_ready, 1'b1);
      chk("rnd rst out_valid", out_valid, 1'b0);
      chk("rnd rst busy", busy, 1'b0);
      chk("rnd rst alu_a", alu_operand_a, 32'd0);
      chk("rnd rst alu_b", alu_operand_b, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;

    // Reset at cycle 20 of a long multiply.
    in_valid = 1'b1; in_mcand = 32'h0000_FFFF; in_mplier = 32'h0000_FFFF;
    wait_cycle();
    in_valid = 1'b0;
    repeat (19) wait_cycle();
    chk("mid busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    wait_cycle();
    rst_n = 1'b1;
    chk("mid rst in_ready", in_ready, 1'b1);
    chk("mid rst out_valid", out_valid, 1'b0);
    chk("mid rst busy", busy, 1'b0);
    run_op(32'd2, 32'd2, 64'd4, 32 + S, "after reset");

    repeat (3) wait_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
